memory_responder: RTL and testbench

//  Memory-side responder for the CPU's memory data/address register pair.

---
 rtl/mem_pkg.sv | 14 +
 rtl/wait_counter.sv | 25 ++
 rtl/memory_responder.sv | 135 +++++++++++++
 tb/tb_memory_responder.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder.
package mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int BITS_DATA_DEF = 32;
  localparam int BITS_ADDR_DEF = 16;

  // clog2 that never returns zero, so derived vectors always have a bit.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/wait_counter.sv
// Wait-state counter: load clears, en advances, done flags the last count.
module wait_counter #(
  parameter int WAIT_CYCLES = 2,
  parameter int CW          = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam logic [CW-1:0] LAST = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (load) cnt <= '0;
    else if (en)   cnt <= cnt + 1'b1;
  end

  assign done = (cnt == LAST);

endmodule

// File: rtl/memory_responder.sv
// Valid/ready memory responder with fixed wait states.
// Optional rspParity output when RESP_PARITY_EN is defined.
module memory_responder
  import mem_pkg::*;
#(
  parameter int BITS_DATA   = BITS_DATA_DEF,
  parameter int BITS_ADDR   = BITS_ADDR_DEF,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 reqValid,
  output logic                 reqReady,
  input  logic                 reqWrite,
  input  logic [BITS_ADDR-1:0] reqAddr,
  input  logic [BITS_DATA-1:0] reqData,
  output logic                 rspValid,
  input  logic                 rspReady,
  output logic [BITS_DATA-1:0] rspData,
  output logic                 rspError
`ifdef RESP_PARITY_EN
  ,
  output logic                 rspParity
`endif
);

  localparam int CW = clog2_min1(WAIT_CYCLES + 1);
  localparam int IW = clog2_min1(DEPTH);

  state_t state, state_nxt;
  logic   armed, load, en, done, commit;

  logic                 lat_write;
  logic [BITS_ADDR-1:0] lat_addr;
  logic [BITS_DATA-1:0] lat_data;

  logic                 src_write;
  logic [BITS_ADDR-1:0] src_addr;
  logic [BITS_DATA-1:0] src_data;
  logic                 in_range;
  logic [IW-1:0]        idx;
  logic [BITS_DATA-1:0] rsp_next;

  logic [BITS_DATA-1:0] mem [DEPTH];

  wait_counter #(.WAIT_CYCLES(WAIT_CYCLES), .CW(CW)) u_wait (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .en   (en),
    .done (done)
  );

  // With zero wait states the commit happens on the accept edge, before the
  // request is latched, so the commit takes its operands straight from the inputs.
  always_comb begin
    src_write = (state == IDLE) ? reqWrite : lat_write;
    src_addr  = (state == IDLE) ? reqAddr  : lat_addr;
    src_data  = (state == IDLE) ? reqData  : lat_data;
    in_range  = 64'(src_addr) < 64'(DEPTH);
    idx       = src_addr[IW-1:0];
    rsp_next  = (in_range && !src_write) ? mem[idx] : '0;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    en        = 1'b0;
    commit    = 1'b0;
    reqReady  = armed && (state == IDLE);
    rspValid  = (state == RESP);
    case (state)
      IDLE: if (reqValid && reqReady) begin
        load = 1'b1;
        if (WAIT_CYCLES == 0) begin
          state_nxt = RESP;
          commit    = 1'b1;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: if (done) begin
        state_nxt = RESP;
        commit    = 1'b1;
      end else begin
        en = 1'b1;
      end
      RESP: if (rspReady) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      armed     <= 1'b0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_data  <= '0;
      rspData   <= '0;
      rspError  <= 1'b0;
`ifdef RESP_PARITY_EN
      rspParity <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
      if (load) begin
        lat_write <= reqWrite;
        lat_addr  <= reqAddr;
        lat_data  <= reqData;
      end
      if (commit) begin
        rspData   <= rsp_next;
        rspError  <= !in_range;
`ifdef RESP_PARITY_EN
        rspParity <= ^rsp_next;
`endif
      end else if (rspValid && rspReady) begin
        rspData   <= '0;
        rspError  <= 1'b0;
`ifdef RESP_PARITY_EN
        rspParity <= 1'b0;
`endif
      end
    end
  end

  // Array is deliberately not reset; out-of-range writes never touch it.
  always_ff @(posedge clk) begin
    if (commit && src_write && in_range) mem[idx] <= src_data;
  end

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench: instance 0 uses 2 wait states, instance 1 uses none.
module tb_memory_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        rv [2];
  logic        rw [2];
  logic [15:0] ra [2];
  logic [31:0] rd [2];
  logic        rr [2];
  logic        qrdy [2];
  logic        sv [2];
  logic [31:0] sd [2];
  logic        se [2];
`ifdef RESP_PARITY_EN
  logic        sp [2];
`endif

  typedef struct packed { logic err; logic [31:0] data; } exp_t;
  exp_t        sbq [$];
  logic [31:0] mdl [int];
  int          checks = 0;
  int          errors = 0;

  memory_responder #(.WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .reqValid(rv[0]), .reqReady(qrdy[0]), .reqWrite(rw[0]),
    .reqAddr(ra[0]), .reqData(rd[0]), .rspValid(sv[0]), .rspReady(rr[0]),
    .rspData(sd[0]), .rspError(se[0])
`ifdef RESP_PARITY_EN
    , .rspParity(sp[0])
`endif
  );

  memory_responder #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .reqValid(rv[1]), .reqReady(qrdy[1]), .reqWrite(rw[1]),
    .reqAddr(ra[1]), .reqData(rd[1]), .rspValid(sv[1]), .rspReady(rr[1]),
    .rspData(sd[1]), .rspError(se[1])
`ifdef RESP_PARITY_EN
    , .rspParity(sp[1])
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // mode 0: normal, 1: reset pulse during WAIT, 2: reset during RESP
  task automatic txn(input int s, input bit wr, input logic [15:0] a, input logic [31:0] d,
                     input int hold, input int mode);
    int          n;
    int          key;
    logic [31:0] held;
    exp_t        e;
    exp_t        got;
    key = s * 65536 + int'(a);
    @(posedge clk); #1;
    rv[s] = 1'b1; rw[s] = wr; ra[s] = a; rd[s] = d;
    n = 0;
    do begin @(negedge clk); n++; end while (!qrdy[s] && n < 20);
    if (!qrdy[s]) begin
      chk("accept_timeout", 32'(n), 32'(0));
      rv[s] = 1'b0;
      return;
    end
    e.err  = (a >= 16'd256);
    e.data = (e.err || wr) ? 32'h0 : mdl[key];
    if (!e.err && wr && mode != 1) mdl[key] = d;
    if (mode != 1) sbq.push_back(e);
    @(posedge clk); #1;
    rv[s] = 1'b0;
    if (mode == 1) begin
      #2 rst_n = 1'b0;
      #1 chk("abort_valid", 32'(sv[s]), 32'(0));
      #1 rst_n = 1'b1;
      return;
    end
    n = 0;
    do begin
      @(negedge clk); n++;
      if (n == 1) chk("busy_ready", 32'(qrdy[s]), 32'(0));
    end while (!sv[s] && n < 20);
    chk("latency", 32'(n), (s == 0) ? 32'(3) : 32'(1));
    held = sd[s];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(sv[s]), 32'(1));
      chk("hold_data", sd[s], held);
      chk("hold_ready", 32'(qrdy[s]), 32'(0));
    end
    got = sbq.pop_front();
    chk("rsp_data", sd[s], got.data);
    chk("rsp_err", 32'(se[s]), 32'(got.err));
`ifdef RESP_PARITY_EN
    chk("rsp_parity", 32'(sp[s]), 32'(^got.data));
`endif
    if (mode == 2) begin
      #2 rst_n = 1'b0;
      #1;
      chk("rst_valid", 32'(sv[s]), 32'(0));
      chk("rst_err", 32'(se[s]), 32'(0));
      chk("rst_ready", 32'(qrdy[s]), 32'(0));
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_ready", 32'(qrdy[s]), 32'(1));
      return;
    end
    rr[s] = 1'b1;
    @(posedge clk); #1;
    rr[s] = 1'b0;
    @(negedge clk);
    chk("retire_valid", 32'(sv[s]), 32'(0));
    chk("retire_data", sd[s], 32'h0);
    chk("retire_err", 32'(se[s]), 32'(0));
    chk("idle_ready", 32'(qrdy[s]), 32'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0; rw[i] = 1'b0; ra[i] = '0; rd[i] = '0; rr[i] = 1'b0;
    end
    #1;
    chk("reset_valid", 32'(sv[0]), 32'(0));
    chk("reset_data", sd[0], 32'h0);
    chk("reset_err", 32'(se[0]), 32'(0));
    chk("reset_ready", 32'(qrdy[0]), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("release_ready_pre", 32'(qrdy[0]), 32'(0));
    @(posedge clk); #1;
    chk("release_ready", 32'(qrdy[0]), 32'(1));

    txn(0, 1'b1, 16'h0000, 32'hCAFEF00D, 0, 0);
    txn(0, 1'b1, 16'h0020, 32'h11111111, 0, 0);
    txn(0, 1'b1, 16'h0010, 32'hDEADBEEF, 0, 0);
    txn(0, 1'b0, 16'h0010, 32'h0,        0, 0);
    txn(0, 1'b0, 16'h0010, 32'h0,        5, 0);
    txn(0, 1'b1, 16'h0100, 32'h12345678, 0, 0);
    txn(0, 1'b0, 16'h0000, 32'h0,        0, 0);
    txn(0, 1'b1, 16'h0020, 32'hA5A5A5A5, 0, 1);
    txn(0, 1'b0, 16'h0020, 32'h0,        0, 0);
    txn(0, 1'b1, 16'hFFFF, 32'h0BADF00D, 0, 2);
    txn(0, 1'b0, 16'h0010, 32'h0,        0, 0);

    txn(1, 1'b1, 16'h0005, 32'h00000007, 0, 0);
    txn(1, 1'b0, 16'h0005, 32'h0,        0, 0);
    txn(1, 1'b0, 16'h0005, 32'h0,        2, 0);
    txn(1, 1'b0, 16'h0200, 32'h0,        0, 0);

    chk("sb_empty", 32'(sbq.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
